// File: rtl/sim_watchdog_pkg.sv
// Shared types for the simulation run controller / watchdog: run state,
// verdict reason and the hart-index width helper.
package sim_watchdog_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RSN_NONE    = 2'd0,
    RSN_EXT     = 2'd1,
    RSN_HANG    = 2'd2,
    RSN_TIMEOUT = 2'd3
  } reason_e;

  localparam int MAX_HARTS = 16;

  // A single hart still needs a one-bit index port.
  function automatic int hart_w(input int nharts);
    return (nharts > 1) ? $clog2(nharts) : 1;
  endfunction

endpackage

// File: rtl/sim_watchdog_stall.sv
// Per-hart no-commit counter: clears on a commit, counts idle RUN cycles
// (saturating) and flags a hang when the count equals a non-zero limit.
module sim_watchdog_stall #(
  parameter int STALL_W = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               run,
  input  logic               valid,
  input  logic [STALL_W-1:0] limit,
  output logic               hang
);

  logic [STALL_W-1:0] stall_q, stall_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    stall_d = stall_q;
    if (run) begin
      if (valid) begin
        stall_d = '0;
      end else if (stall_q != '1) begin
        stall_d = stall_q + STALL_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments and reset
  // asynchronously on the falling edge of reset_n.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign hang = (limit != '0) && (stall_q == limit);

endmodule

// File: rtl/sim_watchdog.sv
// Run controller and watchdog: sticky PASS/FAIL verdict, fail reason,
// cycle/retire counters and wave-dump window. Hang detection is built only
// when SIM_WATCHDOG_HANG_EN is defined.
module sim_watchdog
  import sim_watchdog_pkg::*;
#(
  parameter int NHARTS  = 1,
  parameter int CNT_W   = 64,
  parameter int STALL_W = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CNT_W-1:0]          cfg_max_cycles,
  input  logic [CNT_W-1:0]          cfg_dump_start,
  input  logic                      cfg_dump_en,
  input  logic [STALL_W-1:0]        cfg_stall_limit,
  input  logic [NHARTS-1:0]         trace_valid,
  input  logic                      finish_req,
  input  logic                      fail_req,
  output logic [1:0]                state,
  output logic [1:0]                reason,
  output logic [hart_w(NHARTS)-1:0] fail_hart,
  output logic                      done,
  output logic [CNT_W-1:0]          cycle_cnt,
  output logic [CNT_W-1:0]          retire_cnt,
  output logic                      wave_en
);

  localparam int HART_W = hart_w(NHARTS);
  localparam int POP_W  = $clog2(NHARTS + 1);

  state_e            state_q, state_d;
  reason_e           reason_q, reason_d;
  logic [HART_W-1:0] fail_hart_q, fail_hart_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  retire_q, retire_d;
  logic              wave_q, wave_d;

  logic              run;
  logic [NHARTS-1:0] hang;
  logic              any_hang;
  logic [HART_W-1:0] hang_idx;
  logic              timeout;
  logic [POP_W-1:0]  pop;
  logic [CNT_W:0]    retire_sum;

  assign run = (state_q == ST_RUN);

`ifdef SIM_WATCHDOG_HANG_EN
  for (genvar g = 0; g < NHARTS; g++) begin : g_stall
    sim_watchdog_stall #(
      .STALL_W (STALL_W)
    ) u_stall (
      .clock   (clock),
      .reset_n (reset_n),
      .run     (run),
      .valid   (trace_valid[g]),
      .limit   (cfg_stall_limit),
      .hang    (hang[g])
    );
  end

  // Scanning downwards leaves the lowest hung index as the final winner.
  always_comb begin
    hang_idx = '0;
    for (int i = NHARTS - 1; i >= 0; i--) begin
      if (hang[i]) hang_idx = HART_W'(i);
    end
  end
`else
  logic stall_cfg_unused;
  assign stall_cfg_unused = ^cfg_stall_limit;
  assign hang             = '0;
  assign hang_idx         = '0;
`endif

  assign any_hang = |hang;
  assign timeout  = (cfg_max_cycles != '0) && (cycle_q == cfg_max_cycles);

  always_comb begin
    pop = '0;
    for (int i = 0; i < NHARTS; i++) begin
      pop = pop + POP_W'(trace_valid[i]);
    end
  end

  // One spare bit catches the carry so the retire count can saturate.
  assign retire_sum = {1'b0, retire_q} + (CNT_W + 1)'(pop);

  always_comb begin
    state_d     = state_q;
    reason_d    = reason_q;
    fail_hart_d = fail_hart_q;
    if (run) begin
      if (fail_req) begin
        state_d  = ST_FAIL;
        reason_d = RSN_EXT;
      end else if (any_hang) begin
        state_d     = ST_FAIL;
        reason_d    = RSN_HANG;
        fail_hart_d = hang_idx;
      end else if (timeout) begin
        state_d  = ST_FAIL;
        reason_d = RSN_TIMEOUT;
      end else if (finish_req) begin
        state_d  = ST_PASS;
        reason_d = RSN_NONE;
      end
    end
  end

  // The verdict edge is still a RUN edge, so counters advance on it and
  // freeze from the next edge on.
  always_comb begin
    cycle_d  = cycle_q;
    retire_d = retire_q;
    if (run) begin
      if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
      retire_d = retire_sum[CNT_W] ? '1 : retire_sum[CNT_W-1:0];
    end
  end

  assign done_d = run && (state_d != ST_RUN);
  assign wave_d = cfg_dump_en && (state_d == ST_RUN) && (cycle_d >= cfg_dump_start);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      reason_q    <= RSN_NONE;
      fail_hart_q <= '0;
      done_q      <= 1'b0;
      cycle_q     <= '0;
      retire_q    <= '0;
      wave_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      reason_q    <= reason_d;
      fail_hart_q <= fail_hart_d;
      done_q      <= done_d;
      cycle_q     <= cycle_d;
      retire_q    <= retire_d;
      wave_q      <= wave_d;
    end
  end

  assign state      = state_q;
  assign reason     = reason_q;
  assign fail_hart  = fail_hart_q;
  assign done       = done_q;
  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
  assign wave_en    = wave_q;

endmodule

// File: tb/tb_sim_watchdog.sv
// Scoreboard bench for sim_watchdog (NHARTS=2): directed runs push expected
// verdicts; a monitor pops and compares them whenever done pulses.
module tb_sim_watchdog;
  import sim_watchdog_pkg::*;

  localparam int NHARTS  = 2;
  localparam int CNT_W   = 64;
  localparam int STALL_W = 32;

  typedef struct {
    logic [1:0]  st;
    logic [1:0]  rsn;
    logic [0:0]  hart;
    logic [63:0] cycles;
    logic [63:0] retired;
  } verdict_t;

  logic               clock = 1'b0;
  logic               reset_n = 1'b1;
  logic [CNT_W-1:0]   cfg_max_cycles = '0;
  logic [CNT_W-1:0]   cfg_dump_start = '0;
  logic               cfg_dump_en = 1'b0;
  logic [STALL_W-1:0] cfg_stall_limit = '0;
  logic [NHARTS-1:0]  trace_valid = '0;
  logic               finish_req = 1'b0;
  logic               fail_req = 1'b0;
  logic [1:0]         state;
  logic [1:0]         reason;
  logic [0:0]         fail_hart;
  logic               done;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   retire_cnt;
  logic               wave_en;

  int       n_checks = 0;
  int       n_fail = 0;
  verdict_t sb_q[$];
  verdict_t mon_exp;

  sim_watchdog #(
    .NHARTS  (NHARTS),
    .CNT_W   (CNT_W),
    .STALL_W (STALL_W)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .cfg_max_cycles  (cfg_max_cycles),
    .cfg_dump_start  (cfg_dump_start),
    .cfg_dump_en     (cfg_dump_en),
    .cfg_stall_limit (cfg_stall_limit),
    .trace_valid     (trace_valid),
    .finish_req      (finish_req),
    .fail_req        (fail_req),
    .state           (state),
    .reason          (reason),
    .fail_hart       (fail_hart),
    .done            (done),
    .cycle_cnt       (cycle_cnt),
    .retire_cnt      (retire_cnt),
    .wave_en         (wave_en)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic push_exp(input logic [1:0] st, input logic [1:0] rsn, input logic [0:0] hart,
                          input logic [63:0] cycles, input logic [63:0] retired);
    verdict_t v;
    v.st      = st;
    v.rsn     = rsn;
    v.hart    = hart;
    v.cycles  = cycles;
    v.retired = retired;
    sb_q.push_back(v);
  endtask

  // Monitor: every done pulse must match the oldest expected verdict.
  always @(negedge clock) begin
    if (reset_n && done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with state=%0d, expected no verdict", state);
      end else begin
        mon_exp = sb_q.pop_front();
        check("verdict_state", 64'(state), 64'(mon_exp.st));
        check("verdict_reason", 64'(reason), 64'(mon_exp.rsn));
        check("verdict_fail_hart", 64'(fail_hart), 64'(mon_exp.hart));
        check("verdict_cycle_cnt", cycle_cnt, mon_exp.cycles);
        check("verdict_retire_cnt", retire_cnt, mon_exp.retired);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_verdict(input string name, input int limit);
    int i;
    i = 0;
    while (sb_q.size() != 0 && i < limit) begin
      @(negedge clock);
      #1;
      i++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d verdicts still pending after %0d cycles, expected 0", name, sb_q.size(), limit);
      sb_q.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 64'(state), 64'(ST_RUN));
    check({tag, "_reason"}, 64'(reason), 64'(RSN_NONE));
    check({tag, "_fail_hart"}, 64'(fail_hart), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_cycle_cnt"}, cycle_cnt, 64'd0);
    check({tag, "_retire_cnt"}, retire_cnt, 64'd0);
    check({tag, "_wave_en"}, 64'(wave_en), 64'd0);
  endtask

  // Called at posedge+1; outputs must clear without waiting for a clock.
  task automatic assert_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check_reset_vals(tag);
    @(posedge clock);
    #1;
    trace_valid = '0;
    finish_req  = 1'b0;
    fail_req    = 1'b0;
    reset_n     = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    @(posedge clock);
    #1;
    assert_reset(tag);
  endtask

  task automatic set_cfg(input logic [63:0] max_c, input logic [31:0] stall_l,
                         input logic dump_en, input logic [63:0] dump_s);
    cfg_max_cycles  = max_c;
    cfg_stall_limit = stall_l;
    cfg_dump_en     = dump_en;
    cfg_dump_start  = dump_s;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    // Finish request at RUN cycle 100 -> PASS, counters frozen at 101.
    set_cfg(64'd0, 32'd0, 1'b0, 64'd0);
    do_reset("rst0");
    trace_valid = 2'b01;
    cyc(100);
    finish_req = 1'b1;
    push_exp(ST_PASS, RSN_NONE, 1'b0, 64'd101, 64'd101);
    cyc(1);
    finish_req = 1'b0;
    wait_verdict("pass_wait", 3);
    cyc(1);
    check("pass_done_one_cycle", 64'(done), 64'd0);
    check("pass_sticky_state", 64'(state), 64'(ST_PASS));
    check("pass_cycle_frozen", cycle_cnt, 64'd101);
    check("pass_retire_frozen", retire_cnt, 64'd101);

    // Timeout at max_cycles=50 -> FAIL/TIMEOUT after edge 51.
    set_cfg(64'd50, 32'd0, 1'b0, 64'd0);
    do_reset("rst1");
    trace_valid = 2'b11;
    push_exp(ST_FAIL, RSN_TIMEOUT, 1'b0, 64'd51, 64'd102);
    wait_verdict("timeout_wait", 60);

    // Hart1 last commits at cycle 20; limit 10 -> hang 11 edges later.
    set_cfg(64'd0, 32'd10, 1'b0, 64'd0);
    do_reset("rst2");
    trace_valid = 2'b11;
    cyc(21);
    trace_valid = 2'b01;
    cyc(10);
    check("hang_not_yet", 64'(state), 64'(ST_RUN));
`ifdef SIM_WATCHDOG_HANG_EN
    push_exp(ST_FAIL, RSN_HANG, 1'b1, 64'd32, 64'd53);
    wait_verdict("hang_wait", 5);
`else
    cyc(9);
    check("no_hang_state", 64'(state), 64'(ST_RUN));
    finish_req = 1'b1;
    push_exp(ST_PASS, RSN_NONE, 1'b0, 64'd41, 64'd62);
    cyc(1);
    finish_req = 1'b0;
    wait_verdict("no_hang_finish_wait", 3);
`endif

    // fail_req with finish_req at cycle 30 -> FAIL/EXT; later finish ignored.
    set_cfg(64'd0, 32'd0, 1'b0, 64'd0);
    do_reset("rst3");
    cyc(30);
    fail_req   = 1'b1;
    finish_req = 1'b1;
    push_exp(ST_FAIL, RSN_EXT, 1'b0, 64'd31, 64'd0);
    cyc(1);
    fail_req   = 1'b0;
    finish_req = 1'b0;
    wait_verdict("ext_wait", 3);
    finish_req = 1'b1;
    cyc(3);
    finish_req = 1'b0;
    check("ext_sticky_state", 64'(state), 64'(ST_FAIL));
    check("ext_sticky_reason", 64'(reason), 64'(RSN_EXT));
    check("ext_no_second_done", 64'(done), 64'd0);
    check("ext_cycle_frozen", cycle_cnt, 64'd31);

    // Wave window from cycle 5; PASS at cycle 20 closes it on the same edge.
    set_cfg(64'd0, 32'd0, 1'b1, 64'd5);
    do_reset("rst4");
    trace_valid = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      check($sformatf("wave_en_edge%0d", k), 64'(wave_en), 64'(k >= 5));
    end
    finish_req = 1'b1;
    push_exp(ST_PASS, RSN_NONE, 1'b0, 64'd21, 64'd42);
    cyc(1);
    finish_req = 1'b0;
    check("wave_en_pass_edge", 64'(wave_en), 64'd0);
    wait_verdict("wave_pass_wait", 3);

    // Asynchronous reset at cycle 40 of a run; counting restarts from 0.
    set_cfg(64'd0, 32'd0, 1'b1, 64'd0);
    do_reset("rst5");
    trace_valid = 2'b11;
    cyc(40);
    check("midrun_cycle_cnt", cycle_cnt, 64'd40);
    check("midrun_wave_en", 64'(wave_en), 64'd1);
    assert_reset("midrun_rst");
    trace_valid = 2'b11;
    cyc(3);
    check("restart_cycle_cnt", cycle_cnt, 64'd3);
    check("restart_retire_cnt", retire_cnt, 64'd6);
    check("restart_wave_en", 64'(wave_en), 64'd1);

    // Reset during the done pulse cancels it.
    set_cfg(64'd0, 32'd0, 1'b0, 64'd0);
    do_reset("rst6");
    cyc(5);
    fail_req = 1'b1;
    cyc(1);
    fail_req = 1'b0;
    check("preempt_done_seen", 64'(done), 64'd1);
    assert_reset("preempt_rst");
    cyc(2);
    check("preempt_state_run", 64'(state), 64'(ST_RUN));
    check("preempt_cycle_cnt", cycle_cnt, 64'd2);

    cyc(2);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_watchdog.md
# sim_watchdog

Synthesizable run controller and watchdog for the simulation test harness, generalising the pass/fail/timeout/wave-window logic of the top-level bench into a reusable multi-hart block. It sits beside the SoC model, watches per-hart commit-valid strobes plus external finish/fail requests, and produces a sticky run verdict, fail reason, cycle and retire counters, and a wave-dump enable window. The bench only acts on its outputs: print, close the dump, `$finish` or `$fatal`.

## Interface
- NHARTS, 1: number of monitored harts (1..16)
- CNT_W, 64: width of cycle/retire counters and cycle-based config
- STALL_W, 32: width of the per-hart stall counter and limit
- HART_W, derived: max(1, $clog2(NHARTS))

- clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_max_cycles  in  CNT_W  timeout cycle; 0 disables
- cfg_dump_start  in  CNT_W  first cycle of the wave window
- cfg_dump_en  in  1  wave dumping requested
- cfg_stall_limit  in  STALL_W  per-hart no-commit limit; 0 disables
- trace_valid  in  NHARTS  per-hart commit strobe
- finish_req  in  1  pass request (e.g. tohost/dromajo finish)
- fail_req  in  1  external failure request
- state  out  2  RUN=0, PASS=1, FAIL=2
- reason  out  2  NONE=0, EXT=1, HANG=2, TIMEOUT=3
- fail_hart  out  HART_W  lowest-index hung hart, valid when reason==HANG
- done  out  1  one-cycle pulse on entry to PASS or FAIL
- cycle_cnt  out  CNT_W  cycles spent in RUN
- retire_cnt  out  CNT_W  total commits across all harts
- wave_en  out  1  wave dump window active

## Operation
- FSM states: RUN, PASS, FAIL. PASS and FAIL are terminal and sticky until reset.
- cycle_cnt increments by 1 on every clock edge in RUN and saturates at all-ones.
- retire_cnt adds popcount(trace_valid) each RUN cycle, saturating. Commits in terminal states are ignored.
- Per-hart stall counter:
  - clears on trace_valid[i]; otherwise increments in RUN, saturating.
  - hang[i] = (cfg_stall_limit != 0) && (stall[i] == cfg_stall_limit).
- timeout = (cfg_max_cycles != 0) && (cycle_cnt == cfg_max_cycles).
- Priority is evaluated in RUN each cycle: fail_req > any hang > timeout > finish_req.
  - fail_req: go to FAIL with reason EXT.
  - any hang: go to FAIL with reason HANG; fail_hart = lowest hung index.
  - timeout: go to FAIL with reason TIMEOUT.
  - finish_req alone: go to PASS with reason NONE.
- A failure and finish_req in the same cycle yields FAIL.
- wave_en = cfg_dump_en && state==RUN && cycle_cnt >= cfg_dump_start. It is registered. It drops on the same edge that enters a terminal state.
- Config inputs are treated as static after reset. A change mid-run takes effect on the next compare, with no retroactive trigger.

## Timing
- Reset values (asynchronous):
  - state = RUN, reason = NONE, fail_hart = 0, done = 0.
  - cycle_cnt = 0, retire_cnt = 0, stall counters = 0.
  - wave_en = 0.
- The first edge after reset_n rises is RUN cycle 0. cycle_cnt reads 1 after it.
- Verdict latency is 1 cycle: a request sampled at edge N shows state/reason/done after edge N.
- done is high exactly one cycle. Counters freeze on the same edge the verdict is taken.
- Timeout with cfg_max_cycles=M: FAIL is visible after edge M+1, when cycle_cnt=M is sampled.
- Hang with cfg_stall_limit=L: FAIL is visible L+1 edges after the hart's last commit.
- reset_n assertion at any point, including mid-verdict, clears everything immediately. No done pulse is emitted.

## Configuration
- SIM_WATCHDOG_HANG_EN
  - Defined: per-hart stall counters, HANG detection and fail_hart are built.
  - Undefined: no stall logic; cfg_stall_limit is ignored; fail_hart is tied to 0; reason is never HANG.

## Structure
- Package sim_watchdog_pkg holds the state enum (RUN/PASS/FAIL) and the reason enum (NONE/EXT/HANG/TIMEOUT).
- Sub-module sim_watchdog_stall: one per hart, generate-instanced under SIM_WATCHDOG_HANG_EN.
  - Ports: clock, reset_n, run, valid, limit, hang.
- Top level contains the FSM, the priority encoder, the popcount/saturating counters and the wave window.

## Test plan
- NHARTS=2, max_cycles=0, stall_limit=0, finish_req at RUN cycle 100 -> state=PASS, reason=NONE, done one cycle, cycle_cnt frozen at 101.
- max_cycles=50, no finish -> FAIL/TIMEOUT, done after edge 51, cycle_cnt=51.
- stall_limit=10; hart0 commits every cycle; hart1 stops after cycle 20 -> FAIL/HANG, fail_hart=1, visible 11 edges after hart1's last commit. Without SIM_WATCHDOG_HANG_EN: no FAIL.
- fail_req and finish_req asserted together at cycle 30 -> FAIL/EXT. Later finish_req is ignored; state stays FAIL.
- cfg_dump_en=1, dump_start=5, finish_req at cycle 20 -> wave_en rises after edge 5 and falls on the PASS edge. Both harts valid every cycle -> retire_cnt=2×cycles.
- reset_n pulsed low at cycle 40 of a run -> all outputs return to reset values asynchronously, and counting restarts from 0.
